pipeline_interlock_ctrl: RTL and testbench
==========================================

// Module: pipeline_interlock_ctrl
// PURPOSE
//  Stall/flush controller directly upstream of hazard_detection in the 5-stage RISC-V pipe.
//  Resolves the hazards that forwarding cannot: load-use, memory wait states and taken branches.
//  Drives PC/IF-ID hold, IF-ID/ID-EX flush (bubble) and a stall-cycle statistics counter.
//  After a load-use bubble, the load result reaches ID via hazard_detection's MEM forward path.
// PARAMETERS
//  LOAD_STALL_CYCLES  1   bubbles inserted per load-use hazard (1..7)
//  BRANCH_PENALTY     2   bubbles inserted after a taken branch (1..7)
//  CNT_W              16  width of stall_cycles_r (saturating)
// PORTS
//  clk_i            in   1      clock, rising edge
//  reset_i          in   1      synchronous, active-high reset
//  id_valid_w       in   1      ID holds a real instruction
//  id_ra_index_w    in   5      ID source register A
//  id_rb_index_w    in   5      ID source register B
//  id_ra_used_w     in   1      instruction reads ra
//  id_rb_used_w     in   1      instruction reads rb
//  ex_valid_r       in   1      EX holds a real instruction
//  ex_rd_index_r    in   5      EX destination register
//  ex_is_load_r     in   1      EX instruction is a load
//  branch_taken_w   in   1      EX resolved a taken branch/jump this cycle
//  mem_access_w     in   1      MEM stage has an outstanding access
//  mem_ready_w      in   1      memory completes the access this cycle
//  pc_hold_w        out  1      freeze PC and IF/ID register
//  id_hold_w        out  1      freeze ID/EX inputs (ID re-presents same instr)
//  ex_bubble_w      out  1      load NOP into ID/EX instead of ID instr
//  if_flush_w       out  1      load NOP into IF/ID
//  pipe_freeze_w    out  1      freeze EX/MEM and MEM/WB (memory wait)
//  state_r          out  2      FSM state, debug: 0 RUN 1 LOAD 2 MEMW 3 FLUSH
//  stall_cycles_r   out  CNT_W  cycles with pc_hold_w=1, saturating at all-ones
// BEHAVIOUR
//  Reset: state_r=RUN, internal count=0, stall_cycles_r=0.
//  While reset_i=1, all _w outputs are forced to 0.
//  lu_haz = id_valid_w & ex_valid_r & ex_is_load_r & ex_rd_index_r!=0 &
//           ((id_ra_used_w & ra==rd) | (id_rb_used_w & rb==rd)); x0 never hazards.
//  mem_wait = mem_access_w & ~mem_ready_w.
//  Priority each cycle, any state: mem_wait > branch_taken_w > lu_haz.
//  mem_wait: pc_hold, id_hold, pipe_freeze=1; bubble/flush=0; go MEMW and save the
//    interrupted state and count; count is not decremented.
//  MEMW: outputs as mem_wait while it persists; on mem_ready_w return to the saved
//    state/count the same edge (the ready cycle itself is not frozen).
//  RUN + branch_taken_w (no mem_wait): if_flush=1, ex_bubble=1, pc_hold=0.
//    If BRANCH_PENALTY>1: go FLUSH, cnt=BRANCH_PENALTY-1.
//  FLUSH: ex_bubble=1 each cycle; cnt-- ; cnt reaching 0 -> RUN.
//    A new branch_taken_w in FLUSH is ignored (EX holds bubbles only).
//  RUN + lu_haz: pc_hold=1, id_hold=1, ex_bubble=1.
//    If LOAD_STALL_CYCLES>1: go LOAD, cnt=LOAD_STALL_CYCLES-1.
//  LOAD: same three outputs; cnt-- ; cnt 0 -> RUN.
//    branch_taken_w in LOAD cannot occur (EX holds bubble).
//  Combinational outputs: zero latency from inputs. Registered: state_r, count, stall_cycles_r.
//  stall_cycles_r += 1 on every cycle pc_hold_w=1; holds at 2^CNT_W-1.
//  Reset mid-operation: returns to RUN next edge; pending bubbles/flushes are abandoned.
// TESTING
//  1. ex load rd=5, id ra=5 used -> 1 cycle pc_hold/id_hold/ex_bubble=1; next cycle all 0; stall_cycles_r=1.
//  2. ex load rd=0, id ra=0 -> no stall; ex non-load rd=5, id rb=5 -> no stall (forwarding).
//  3. branch_taken_w 1 cycle, BRANCH_PENALTY=2 -> if_flush 1 cycle, ex_bubble 2 cycles, pc_hold=0 throughout.
//  4. mem_access_w=1, mem_ready_w=0 for 3 cycles during a load-use stall -> pipe_freeze 3 cycles, then exactly 1 bubble.
//  5. Load-use and mem_wait in the same cycle -> freeze only; the load-use bubble follows once mem_ready_w=1.
//  6. reset_i in FLUSH with cnt=1 -> next cycle state_r=0, outputs 0; CNT_W=4, 20 stalls -> stall_cycles_r=15.

Source files
------------

// File: rtl/pipeline_interlock_ctrl.sv
// rtl/pipeline_interlock_ctrl.sv - stall/flush interlock controller for the 5-stage pipe
//
// Resolves the hazards that forwarding cannot cover: load-use, memory wait
// states and taken branches. Hold/bubble/flush/freeze outputs are combinational
// from the current state and inputs. state_r, the bubble count and
// stall_cycles_r are registered.
//
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   id_*                            ID-stage instruction: valid, source indices, source-used flags
//   ex_valid_r/ex_rd_index_r/ex_is_load_r   EX-stage instruction info
//   branch_taken_w                  EX resolved a taken branch/jump this cycle
//   mem_access_w, mem_ready_w       MEM-stage access handshake
//   pc_hold_w, id_hold_w            freeze PC + IF/ID, freeze ID/EX inputs
//   ex_bubble_w, if_flush_w         NOP into ID/EX, NOP into IF/ID
//   pipe_freeze_w                   freeze EX/MEM and MEM/WB
//   state_r                         debug state: 0 RUN, 1 LOAD, 2 MEMW, 3 FLUSH
//   stall_cycles_r                  saturating count of pc_hold_w cycles
module pipeline_interlock_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BRANCH_PENALTY    = 2,
    parameter int CNT_W             = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             id_valid_w,
    input  logic [4:0]       id_ra_index_w,
    input  logic [4:0]       id_rb_index_w,
    input  logic             id_ra_used_w,
    input  logic             id_rb_used_w,
    input  logic             ex_valid_r,
    input  logic [4:0]       ex_rd_index_r,
    input  logic             ex_is_load_r,
    input  logic             branch_taken_w,
    input  logic             mem_access_w,
    input  logic             mem_ready_w,
    output logic             pc_hold_w,
    output logic             id_hold_w,
    output logic             ex_bubble_w,
    output logic             if_flush_w,
    output logic             pipe_freeze_w,
    output logic [1:0]       state_r,
    output logic [CNT_W-1:0] stall_cycles_r
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LOAD  = 2'd1,
        S_MEMW  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t             r_state;
    state_t             r_saved_state;
    logic [2:0]         r_cnt;
    logic [2:0]         r_saved_cnt;
    logic [CNT_W-1:0]   r_stall;

    logic               w_lu_haz;
    logic               w_mem_wait;
    state_t             w_eff_state;
    logic [2:0]         w_eff_cnt;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    assign w_lu_haz = id_valid_w & ex_valid_r & ex_is_load_r & (ex_rd_index_r != 5'd0) &
                      ((id_ra_used_w & (id_ra_index_w == ex_rd_index_r)) |
                       (id_rb_used_w & (id_rb_index_w == ex_rd_index_r)));

    assign w_mem_wait = mem_access_w & ~mem_ready_w;

    // Once the memory wait clears, the cycle behaves exactly as the interrupted
    // state would have, so the ready cycle itself already does useful work.
    assign w_eff_state = (r_state == S_MEMW) ? r_saved_state : r_state;
    assign w_eff_cnt   = (r_state == S_MEMW) ? r_saved_cnt   : r_cnt;

    assign state_r        = r_state;
    assign stall_cycles_r = r_stall;

    always_comb begin
        pc_hold_w     = 1'b0;
        id_hold_w     = 1'b0;
        ex_bubble_w   = 1'b0;
        if_flush_w    = 1'b0;
        pipe_freeze_w = 1'b0;
        if (!reset_i) begin
            if (w_mem_wait) begin
                pc_hold_w     = 1'b1;
                id_hold_w     = 1'b1;
                pipe_freeze_w = 1'b1;
            end else begin
                case (w_eff_state)
                    S_RUN: begin
                        if (branch_taken_w) begin
                            if_flush_w  = 1'b1;
                            ex_bubble_w = 1'b1;
                        end else if (w_lu_haz) begin
                            pc_hold_w   = 1'b1;
                            id_hold_w   = 1'b1;
                            ex_bubble_w = 1'b1;
                        end
                    end
                    S_LOAD: begin
                        pc_hold_w   = 1'b1;
                        id_hold_w   = 1'b1;
                        ex_bubble_w = 1'b1;
                    end
                    // EX only holds bubbles here, so a branch indication is ignored.
                    S_FLUSH: ex_bubble_w = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state       <= S_RUN;
            r_saved_state <= S_RUN;
            r_cnt         <= 3'd0;
            r_saved_cnt   <= 3'd0;
            r_stall       <= '0;
        end else begin
            if (pc_hold_w && (r_stall != {CNT_W{1'b1}})) begin
                r_stall <= r_stall + 1'b1;
            end
            if (w_mem_wait) begin
                // Keep the first interrupted context if the wait spans several cycles.
                if (r_state != S_MEMW) begin
                    r_saved_state <= r_state;
                    r_saved_cnt   <= r_cnt;
                end
                r_state <= S_MEMW;
            end else begin
                case (w_eff_state)
                    S_RUN: begin
                        r_state <= S_RUN;
                        if (branch_taken_w) begin
                            if (BRANCH_PENALTY > 1) begin
                                r_state <= S_FLUSH;
                                r_cnt   <= 3'(BRANCH_PENALTY - 1);
                            end
                        end else if (w_lu_haz) begin
                            if (LOAD_STALL_CYCLES > 1) begin
                                r_state <= S_LOAD;
                                r_cnt   <= 3'(LOAD_STALL_CYCLES - 1);
                            end
                        end
                    end
                    S_LOAD, S_FLUSH: begin
                        r_cnt   <= w_eff_cnt - 3'd1;
                        r_state <= (w_eff_cnt == 3'd1) ? S_RUN : w_eff_state;
                    end
                    default: r_state <= S_RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// tb/tb_pipeline_interlock_ctrl.sv - self-checking bench for pipeline_interlock_ctrl
module tb_pipeline_interlock_ctrl;

    logic       clk_i;
    logic       reset_i;
    logic       id_valid_w;
    logic [4:0] id_ra_index_w;
    logic [4:0] id_rb_index_w;
    logic       id_ra_used_w;
    logic       id_rb_used_w;
    logic       ex_valid_r;
    logic [4:0] ex_rd_index_r;
    logic       ex_is_load_r;
    logic       branch_taken_w;
    logic       mem_access_w;
    logic       mem_ready_w;

    logic        pc_hold[2];
    logic        id_hold[2];
    logic        ex_bubble[2];
    logic        if_flush[2];
    logic        pipe_freeze[2];
    logic [1:0]  state[2];
    logic [3:0]  stall_a;
    logic [15:0] stall_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: remaining bubble cycles and what kind of interlock owns them.
    int m_kind[2];
    int m_left[2];
    int m_cnt[2];
    int p_lsc[2]  = '{1, 3};
    int p_bp[2]   = '{2, 3};
    int p_cmax[2] = '{15, 65535};

    // A: LSC=1, BP=2, CNT_W=4.  B: LSC=3, BP=3, CNT_W=16.
    pipeline_interlock_ctrl #(.LOAD_STALL_CYCLES(1), .BRANCH_PENALTY(2), .CNT_W(4)) u_dut_a (
        .clk_i(clk_i), .reset_i(reset_i), .id_valid_w(id_valid_w),
        .id_ra_index_w(id_ra_index_w), .id_rb_index_w(id_rb_index_w),
        .id_ra_used_w(id_ra_used_w), .id_rb_used_w(id_rb_used_w),
        .ex_valid_r(ex_valid_r), .ex_rd_index_r(ex_rd_index_r), .ex_is_load_r(ex_is_load_r),
        .branch_taken_w(branch_taken_w), .mem_access_w(mem_access_w), .mem_ready_w(mem_ready_w),
        .pc_hold_w(pc_hold[0]), .id_hold_w(id_hold[0]), .ex_bubble_w(ex_bubble[0]),
        .if_flush_w(if_flush[0]), .pipe_freeze_w(pipe_freeze[0]),
        .state_r(state[0]), .stall_cycles_r(stall_a)
    );

    pipeline_interlock_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_PENALTY(3), .CNT_W(16)) u_dut_b (
        .clk_i(clk_i), .reset_i(reset_i), .id_valid_w(id_valid_w),
        .id_ra_index_w(id_ra_index_w), .id_rb_index_w(id_rb_index_w),
        .id_ra_used_w(id_ra_used_w), .id_rb_used_w(id_rb_used_w),
        .ex_valid_r(ex_valid_r), .ex_rd_index_r(ex_rd_index_r), .ex_is_load_r(ex_is_load_r),
        .branch_taken_w(branch_taken_w), .mem_access_w(mem_access_w), .mem_ready_w(mem_ready_w),
        .pc_hold_w(pc_hold[1]), .id_hold_w(id_hold[1]), .ex_bubble_w(ex_bubble[1]),
        .if_flush_w(if_flush[1]), .pipe_freeze_w(pipe_freeze[1]),
        .state_r(state[1]), .stall_cycles_r(stall_b)
    );

    // Output vector order: {pc_hold, id_hold, ex_bubble, if_flush, pipe_freeze}
    wire [4:0] outs_a = {pc_hold[0], id_hold[0], ex_bubble[0], if_flush[0], pipe_freeze[0]};
    wire [4:0] outs_b = {pc_hold[1], id_hold[1], ex_bubble[1], if_flush[1], pipe_freeze[1]};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic set_in(input bit v, input logic [4:0] ra, input logic [4:0] rb,
                          input bit rau, input bit rbu, input bit exv,
                          input logic [4:0] rd, input bit ld, input bit br,
                          input bit ma, input bit mr);
        id_valid_w     = v;
        id_ra_index_w  = ra;
        id_rb_index_w  = rb;
        id_ra_used_w   = rau;
        id_rb_used_w   = rbu;
        ex_valid_r     = exv;
        ex_rd_index_r  = rd;
        ex_is_load_r   = ld;
        branch_taken_w = br;
        mem_access_w   = ma;
        mem_ready_w    = mr;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    function automatic bit lu_ref();
        if (!(id_valid_w && ex_valid_r && ex_is_load_r) || ex_rd_index_r == 5'd0) return 1'b0;
        return (id_ra_used_w && id_ra_index_w == ex_rd_index_r) ||
               (id_rb_used_w && id_rb_index_w == ex_rd_index_r);
    endfunction

    task automatic model_step(input int k, input bit rst, input bit lu, input bit br,
                              input bit mw, output logic [4:0] e, output logic [1:0] es);
        if (rst) begin
            e = 5'b00000; es = 2'd0;
            m_kind[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
            return;
        end
        if (mw) begin
            e = 5'b11001;
        end else if (m_left[k] > 0) begin
            e = (m_kind[k] == 1) ? 5'b11100 : 5'b00100;
            m_left[k]--;
        end else if (br) begin
            e = 5'b00110;
            m_kind[k] = 2; m_left[k] = p_bp[k] - 1;
        end else if (lu) begin
            e = 5'b11100;
            m_kind[k] = 1; m_left[k] = p_lsc[k] - 1;
        end else begin
            e = 5'b00000;
        end
        if (e[4] && m_cnt[k] < p_cmax[k]) m_cnt[k]++;
        if (mw)              es = 2'd2;
        else if (m_left[k] > 0) es = (m_kind[k] == 1) ? 2'd1 : 2'd3;
        else                 es = 2'd0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        set_in(1, 5, 0, 1, 0, 1, 5, 1, 1, 1, 0);
        #1;
        n_assert++;
        if (outs_a !== 5'b00000) begin n_fail++; $display("FAIL reset_outs got %b want 00000", outs_a); end
        @(posedge clk_i); #1;
        n_assert++;
        if (state[0] !== 2'd0 || stall_a !== 4'd0) begin
            n_fail++; $display("FAIL reset_state got state=%0d stall=%0d want 0/0", state[0], stall_a);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use();
        apply_reset();
        set_in(1, 5, 7, 1, 1, 1, 5, 1, 0, 0, 0);
        #1;
        n_assert++;
        if (outs_a !== 5'b11100) begin n_fail++; $display("FAIL lu_stall got %b want 11100", outs_a); end
        @(posedge clk_i); #1;
        n_assert++;
        if (state[0] !== 2'd0 || stall_a !== 4'd1) begin
            n_fail++; $display("FAIL lu_count got state=%0d stall=%0d want 0/1", state[0], stall_a);
        end
        @(negedge clk_i);
        set_in(1, 5, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        n_assert++;
        if (outs_a !== 5'b00000) begin n_fail++; $display("FAIL lu_release got %b want 00000", outs_a); end
    endtask

    task automatic test_no_stall();
        apply_reset();
        set_in(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0);
        #1;
        n_assert++;
        if (outs_a !== 5'b00000) begin n_fail++; $display("FAIL x0_load got %b want 00000", outs_a); end
        @(negedge clk_i);
        set_in(1, 3, 5, 1, 1, 1, 5, 0, 0, 0, 0);
        #1;
        n_assert++;
        if (outs_a !== 5'b00000) begin n_fail++; $display("FAIL forward_alu got %b want 00000", outs_a); end
        @(negedge clk_i);
        set_in(1, 3, 5, 1, 0, 1, 5, 1, 0, 0, 0);
        #1;
        n_assert++;
        if (outs_a !== 5'b00000) begin n_fail++; $display("FAIL rb_unused got %b want 00000", outs_a); end
    endtask

    task automatic test_branch();
        logic [4:0] want[3] = '{5'b00110, 5'b00100, 5'b00000};
        logic [1:0] wst[3]  = '{2'd3, 2'd0, 2'd0};
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0, (c == 0), 0, 0);
            #1;
            n_assert++;
            if (outs_a !== want[c]) begin n_fail++; $display("FAIL branch_c%0d got %b want %b", c, outs_a, want[c]); end
            @(posedge clk_i); #1;
            n_assert++;
            if (state[0] !== wst[c]) begin n_fail++; $display("FAIL branch_st%0d got %0d want %0d", c, state[0], wst[c]); end
            @(negedge clk_i);
        end
    endtask

    task automatic test_mem_wait_in_stall();
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            if (c < 3)       set_in(1, 5, 0, 1, 0, 1, 5, 1, 0, 1, 0);
            else if (c == 3) set_in(1, 5, 0, 1, 0, 1, 5, 1, 0, 1, 1);
            else             set_in(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            #1;
            n_assert++;
            if (outs_a !== (c < 3 ? 5'b11001 : (c == 3 ? 5'b11100 : 5'b00000))) begin
                n_fail++; $display("FAIL memw_c%0d got %b", c, outs_a);
            end
            @(posedge clk_i); #1;
            n_assert++;
            if (state[0] !== (c < 3 ? 2'd2 : 2'd0)) begin
                n_fail++; $display("FAIL memw_st%0d got %0d", c, state[0]);
            end
            @(negedge clk_i);
        end
        n_assert++;
        if (stall_a !== 4'd4) begin n_fail++; $display("FAIL memw_count got %0d want 4", stall_a); end
    endtask

    task automatic test_lu_and_memw_same_cycle();
        // Instance B: freeze first, then the 3-cycle load stall, with a second wait mid-LOAD.
        logic [4:0] want[7] = '{5'b11001, 5'b11100, 5'b11001, 5'b11001, 5'b11100, 5'b11100, 5'b00000};
        logic [1:0] wst[7]  = '{2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            set_in(1, 9, 0, 1, 0, (c < 2), 9, 1, 0, (c == 0 || c == 2 || c == 3), 0);
            #1;
            n_assert++;
            if (outs_b !== want[c]) begin n_fail++; $display("FAIL lumw_c%0d got %b want %b", c, outs_b, want[c]); end
            @(posedge clk_i); #1;
            n_assert++;
            if (state[1] !== wst[c]) begin n_fail++; $display("FAIL lumw_st%0d got %0d want %0d", c, state[1], wst[c]); end
            @(negedge clk_i);
        end
        n_assert++;
        if (stall_b !== 16'd6) begin n_fail++; $display("FAIL lumw_count got %0d want 6", stall_b); end
    endtask

    task automatic test_reset_in_flush();
        apply_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk_i); #1;
        n_assert++;
        if (state[0] !== 2'd3) begin n_fail++; $display("FAIL rflush_enter got %0d want 3", state[0]); end
        @(negedge clk_i);
        reset_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_assert++;
        if (outs_a !== 5'b00000) begin n_fail++; $display("FAIL rflush_outs got %b want 00000", outs_a); end
        @(posedge clk_i); #1;
        n_assert++;
        if (state[0] !== 2'd0) begin n_fail++; $display("FAIL rflush_state got %0d want 0", state[0]); end
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        n_assert++;
        if (outs_a !== 5'b00000) begin n_fail++; $display("FAIL rflush_after got %b want 00000", outs_a); end
    endtask

    task automatic test_saturation();
        apply_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (20) @(posedge clk_i);
        #1;
        n_assert++;
        if (stall_a !== 4'd15) begin n_fail++; $display("FAIL sat_a got %0d want 15", stall_a); end
        n_assert++;
        if (stall_b !== 16'd20) begin n_fail++; $display("FAIL sat_b got %0d want 20", stall_b); end
        @(negedge clk_i);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [4:0] e[2];
        logic [1:0] es[2];
        bit rst, lu, mw;
        apply_reset();
        for (int k = 0; k < 2; k++) begin m_kind[k] = 0; m_left[k] = 0; m_cnt[k] = 0; end
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            reset_i = rst;
            set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 6) == 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 1));
            #1;
            lu = lu_ref();
            mw = mem_access_w && !mem_ready_w;
            for (int k = 0; k < 2; k++) model_step(k, rst, lu, branch_taken_w, mw, e[k], es[k]);
            n_assert++;
            if (outs_a !== e[0]) begin n_fail++; $display("FAIL rnd_outs_a c%0d got %b want %b", c, outs_a, e[0]); end
            n_assert++;
            if (outs_b !== e[1]) begin n_fail++; $display("FAIL rnd_outs_b c%0d got %b want %b", c, outs_b, e[1]); end
            @(posedge clk_i); #1;
            n_assert++;
            if (state[0] !== es[0] || stall_a !== 4'(m_cnt[0])) begin
                n_fail++; $display("FAIL rnd_reg_a c%0d got %0d/%0d want %0d/%0d", c, state[0], stall_a, es[0], m_cnt[0]);
            end
            n_assert++;
            if (state[1] !== es[1] || stall_b !== 16'(m_cnt[1])) begin
                n_fail++; $display("FAIL rnd_reg_b c%0d got %0d/%0d want %0d/%0d", c, state[1], stall_b, es[1], m_cnt[1]);
            end
            @(negedge clk_i);
        end
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait_in_stall();
        test_lu_and_memw_same_cycle();
        test_reset_in_flush();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
